// File: rtl/key_debounce_pulse.sv
// ---------------------------------------------------------------------------
// key_debounce_pulse
//
// Turns a raw, bouncy push-button pin into clean single-cycle events for the
// LED timer/control logic downstream. The pin is brought into the clk domain
// through a two-flop synchroniser. A counter-based state machine then accepts
// a level change only after the synchronised value has held for DB_CYCLES
// consecutive cycles.
//
// Ports
//   clk           in   system clock (50 MHz)
//   rst           in   synchronous, active-high reset
//   key_in        in   raw button pin, asynchronous to clk, may bounce
//   key_level     out  debounced state, 1 = pressed
//   press_pulse   out  one-cycle strobe on an accepted press
//   release_pulse out  one-cycle strobe on an accepted release
//   long_pulse    out  one-cycle strobe once a press has been held LONG_CYCLES
//   dbg_state     out  current FSM state (state_t encoding), for observation
//
// There is no valid/ready handshake. Every output is a registered strobe or
// level. Downstream logic samples it on any clk edge and cannot stall it.
// ---------------------------------------------------------------------------
module key_debounce_pulse #(
  parameter int unsigned DB_CYCLES      = 1_000_000,
  parameter int unsigned LONG_CYCLES    = 100_000_000,
  parameter bit          KEY_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_in,
  output logic       key_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } state_t;

  // The db_cnt value at which the next agreeing sample completes DB_CYCLES.
  localparam logic [31:0] DB_LAST   = 32'(DB_CYCLES - 1);
  localparam logic [31:0] LONG_MAX  = 32'(LONG_CYCLES);
  localparam logic [31:0] LONG_LAST = 32'(LONG_CYCLES - 1);
  // Pin level while the button is not pressed.
  localparam logic        PIN_RELEASED = KEY_ACTIVE_LOW;

  logic        r_sync1;
  logic        r_sync2;
  logic        w_s;
  state_t      r_state;
  logic [31:0] r_db_cnt;
  logic [31:0] r_hold_cnt;
  logic        r_key_level;
  logic        r_press_pulse;
  logic        r_release_pulse;
  logic        r_long_pulse;

  // Two-flop synchroniser. Reset loads the released level, so a button held
  // through reset is seen as a fresh press once reset is released.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= PIN_RELEASED;
      r_sync2 <= PIN_RELEASED;
    end else begin
      r_sync1 <= key_in;
      r_sync2 <= r_sync1;
    end
  end

  // Normalised key: 1 = pressed, regardless of pin polarity.
  assign w_s = r_sync2 ^ KEY_ACTIVE_LOW;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_db_cnt        <= '0;
      r_hold_cnt      <= '0;
      r_key_level     <= 1'b0;
      r_press_pulse   <= 1'b0;
      r_release_pulse <= 1'b0;
      r_long_pulse    <= 1'b0;
    end else begin
      // Strobes default low, so each one lasts exactly one cycle.
      r_press_pulse   <= 1'b0;
      r_release_pulse <= 1'b0;
      r_long_pulse    <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          r_key_level <= 1'b0;
          if (w_s) begin
            r_state  <= ST_PRESS_WAIT;
            r_db_cnt <= 32'd1;
          end
        end

        ST_PRESS_WAIT: begin
          if (!w_s) begin
            // Glitch rejected. The next press restarts the count from scratch.
            r_state  <= ST_IDLE;
            r_db_cnt <= '0;
          end else if (r_db_cnt == DB_LAST) begin
            r_state       <= ST_PRESSED;
            r_key_level   <= 1'b1;
            r_press_pulse <= 1'b1;
            r_hold_cnt    <= '0;
            r_db_cnt      <= '0;
          end else begin
            r_db_cnt <= r_db_cnt + 32'd1;
          end
        end

        ST_PRESSED: begin
          // Saturating hold counter. The strobe fires only on the single
          // LONG-1 -> LONG step, so long_pulse fires at most once per press.
          if (r_hold_cnt != LONG_MAX) begin
            r_hold_cnt <= r_hold_cnt + 32'd1;
            if (r_hold_cnt == LONG_LAST) begin
              r_long_pulse <= 1'b1;
            end
          end
          if (!w_s) begin
            r_state  <= ST_RELEASE_WAIT;
            r_db_cnt <= 32'd1;
          end
        end

        ST_RELEASE_WAIT: begin
          // The hold counter is frozen here. A bounce back to pressed resumes
          // the count where it left off.
          if (w_s) begin
            r_state  <= ST_PRESSED;
            r_db_cnt <= '0;
          end else if (r_db_cnt == DB_LAST) begin
            r_state         <= ST_IDLE;
            r_key_level     <= 1'b0;
            r_release_pulse <= 1'b1;
            r_db_cnt        <= '0;
          end else begin
            r_db_cnt <= r_db_cnt + 32'd1;
          end
        end

        default: begin
          r_state  <= ST_IDLE;
          r_db_cnt <= '0;
        end
      endcase
    end
  end

  assign key_level     = r_key_level;
  assign press_pulse   = r_press_pulse;
  assign release_pulse = r_release_pulse;
  assign long_pulse    = r_long_pulse;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_key_debounce_pulse.sv
// ---------------------------------------------------------------------------
// Bench for key_debounce_pulse (DB_CYCLES = 8, LONG_CYCLES = 32, active-low
// pin).
//
// Reference model:
// - The pin reaches the debouncer through a two-deep delay line.
// - The debounced level flips once DB consecutive samples disagree with it.
// - The hold count advances on every edge spent stably pressed, meaning the
//   level is 1 and no disagreeing sample is pending.
//
// Edge numbering: cyc counts rising edges. The first edge that samples a new
// pin level is t0. The strobe lands on edge t0 + DB + 1, which is the
// (DB+2)-th edge when t0 itself is counted as edge 1.
// ---------------------------------------------------------------------------
module tb_key_debounce_pulse;
  localparam int DB   = 8;
  localparam int LONG = 32;

  // clock / reset block
  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic key_in = 1'b1;
  always #10 clk = ~clk;

  logic       key_level, press_pulse, release_pulse, long_pulse;
  logic [1:0] dbg_state;

  key_debounce_pulse #(
    .DB_CYCLES(DB), .LONG_CYCLES(LONG), .KEY_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .key_in(key_in),
    .key_level(key_level), .press_pulse(press_pulse),
    .release_pulse(release_pulse), .long_pulse(long_pulse),
    .dbg_state(dbg_state)
  );

  int total = 0;
  int bad   = 0;

  // behavioural model -> expected queue {level, press, release, long}
  logic [3:0] exp_q[$];
  int         cyc = 0;
  logic [1:0] pin_hist = 2'b11;
  logic       m_level = 1'b0;
  int         m_run = 0;
  int         m_hold = 0;
  logic       m_s, m_pp, m_rp, m_lp;

  always @(posedge clk) begin
    cyc = cyc + 1;
    m_pp = 1'b0; m_rp = 1'b0; m_lp = 1'b0;
    if (rst) begin
      pin_hist = 2'b11;
      m_level  = 1'b0;
      m_run    = 0;
      m_hold   = 0;
    end else begin
      m_s = ~pin_hist[1];
      // Hold time accrues only while stably pressed, judged before this edge.
      if (m_level && m_run == 0 && m_hold < LONG) begin
        m_hold = m_hold + 1;
        if (m_hold == LONG) m_lp = 1'b1;
      end
      if (m_s != m_level) m_run = m_run + 1;
      else                m_run = 0;
      if (m_run == DB) begin
        m_level = m_s;
        m_pp    = m_s;
        m_rp    = ~m_s;
        m_run   = 0;
        if (m_s) m_hold = 0;
      end
      pin_hist = {pin_hist[0], key_in};
    end
    exp_q.push_back({m_level, m_pp, m_rp, m_lp});
  end

  // compare process + pulse monitor, sampled on the falling edge
  int n_press = 0, n_release = 0, n_long = 0;
  int last_press = -1, last_release = -1, last_long = -1;
  logic [3:0] exp_v, act_v;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {key_level, press_pulse, release_pulse, long_pulse};
      total = total + 1;
      if (act_v !== exp_v) begin
        bad = bad + 1;
        $display("FAIL model cyc=%0d outputs{lvl,prs,rel,lng}: got %b expected %b",
                 cyc, act_v, exp_v);
      end
    end
    if (press_pulse === 1'b1)   begin n_press++;   last_press   = cyc; end
    if (release_pulse === 1'b1) begin n_release++; last_release = cyc; end
    if (long_pulse === 1'b1)    begin n_long++;    last_long    = cyc; end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input int act, input int exp);
    total = total + 1;
    if (act != exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  int t0, r_edge, bp, br, bl;

  initial begin
    tick(3);
    check("reset_outputs", {key_level, press_pulse, release_pulse, long_pulse}, 0);
    check("reset_state_idle", dbg_state, 0);
    rst = 1'b0;
    tick(5);

    // 1. clean press, then 3. long hold and release
    bp = n_press; br = n_release; bl = n_long;
    key_in = 1'b0; t0 = cyc + 1;
    tick(20);
    check("clean_press_count", n_press - bp, 1);
    check("clean_press_edge", last_press, t0 + DB + 1);
    check("clean_level", key_level, 1);
    tick(45);
    check("long_count", n_long - bl, 1);
    check("long_edge", last_long, last_press + LONG);
    key_in = 1'b1; t0 = cyc + 1;
    tick(20);
    check("long_release_count", n_release - br, 1);
    check("long_release_edge", last_release, t0 + DB + 1);
    check("long_single", n_long - bl, 1);

    // 4. short press: release sampled 20 edges after press_pulse
    bp = n_press; br = n_release; bl = n_long;
    key_in = 1'b0; t0 = cyc + 1;
    tick(29);
    key_in = 1'b1;
    tick(20);
    check("short_press_count", n_press - bp, 1);
    check("short_release_count", n_release - br, 1);
    check("short_no_long", n_long - bl, 0);

    // 2. bounce every 3 cycles for 30 cycles, then held pressed
    bp = n_press;
    for (int i = 0; i < 10; i++) begin
      key_in = (i % 2 == 0) ? 1'b0 : 1'b1;
      tick(3);
    end
    key_in = 1'b0; t0 = cyc + 1;
    tick(20);
    check("bounce_press_count", n_press - bp, 1);
    check("bounce_press_edge", last_press, t0 + DB + 1);
    key_in = 1'b1;
    tick(20);

    // 6. one-cycle release glitch while pressed
    key_in = 1'b0;
    tick(20);
    br = n_release;
    key_in = 1'b1; tick(1); key_in = 1'b0;
    tick(20);
    check("glitch_no_release", n_release - br, 0);
    check("glitch_level", key_level, 1);
    key_in = 1'b1; t0 = cyc + 1;
    tick(20);
    check("glitch_real_release", n_release - br, 1);
    check("glitch_release_edge", last_release, t0 + DB + 1);

    // 5. reset during PRESSED with the key held across reset
    key_in = 1'b0;
    tick(20);
    bp = n_press; br = n_release;
    rst = 1'b1;
    tick(1);
    check("midrst_outputs", {key_level, press_pulse, release_pulse, long_pulse}, 0);
    tick(2);
    rst = 1'b0; r_edge = cyc;
    tick(20);
    check("rst_press_count", n_press - bp, 1);
    check("rst_press_edge", last_press, r_edge + DB + 2);
    check("rst_no_release", n_release - br, 0);
    key_in = 1'b1;
    tick(20);

    // randomized segments, checked every cycle by the model
    for (int seg = 0; seg < 300; seg++) begin
      key_in = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 40) == 0) begin
        rst = 1'b1;
        tick($urandom_range(1, 3));
        rst = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) tick($urandom_range(10, 50));
      else                           tick($urandom_range(1, 10));
    end
    key_in = 1'b1;
    tick(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
